// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port variable-latency memory between fetch and data stages,
// preferring data but forcing a fetch after MAX_D_STREAK consecutive data grants.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                if_req,
    input  logic                if_flush,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    output logic                if_stall,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, FETCH, DATA, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [3:0]          streak_q, streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic                fetch_ok, grant_f, grant_d;

    assign fetch_ok = if_req & ~if_flush;
    // Fetch wins in IDLE only when data is absent or has used up its streak.
    assign grant_f  = (state_q == IDLE) & fetch_ok & (~d_req | (streak_q == MAX_S));
    assign grant_d  = (state_q == IDLE) & d_req & ~grant_f;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        case (state_q)
            IDLE: begin
                if (grant_f) begin
                    state_d     = FETCH;
                    streak_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                end else if (grant_d) begin
                    state_d     = DATA;
                    streak_d    = ~if_req ? 4'd0 : (streak_q == MAX_S) ? streak_q : streak_q + 4'd1;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (if_flush) begin
                    state_d = DRAIN;
                end
            end
            default: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign if_ack    = (state_q == FETCH) & mem_ready & ~if_flush;
    assign d_ack     = (state_q == DATA) & mem_ready;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign if_stall  = if_req & ~if_ack;
    assign d_stall   = d_req & ~d_ack;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed bench for the fetch/data memory arbiter.
module tb_unified_mem_arbiter;
    logic        CLK = 1'b0;
    logic        RESETn;
    logic        if_req, if_flush, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ack, if_stall, d_ack, d_stall, mem_req, mem_we;
    logic [3:0]  mem_be;
    int          checks = 0;
    int          failures = 0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .if_req(if_req), .if_flush(if_flush), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RESETn = 1'b0; if_req = 0; if_flush = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_d_ack", d_ack, 0);
        RESETn = 1'b1;
        tick();
        // 1: single-cycle fetch
        if_req = 1; if_addr = 32'h100; #1;
        chk("t1_stall_grant", if_stall, 1);
        chk("t1_req_grant", mem_req, 0);
        tick();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_we", mem_we, 0);
        chk("t1_mem_be", mem_be, 4'hf);
        mem_ready = 1; mem_rdata = 32'h13; #1;
        chk("t1_if_ack", if_ack, 1);
        chk("t1_if_rdata", if_rdata, 32'h13);
        chk("t1_if_stall_ack", if_stall, 0);
        tick();
        chk("t1_mem_req_drop", mem_req, 0);
        if_req = 0; mem_ready = 0; #1;
        chk("t1_if_stall_after", if_stall, 0);
        // 2: store with 3-cycle wait
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_be = 4'b0011; #1;
        chk("t2_stall_c1", d_stall, 1);
        tick();
        chk("t2_mem_req", mem_req, 1);
        chk("t2_mem_we", mem_we, 1);
        chk("t2_mem_addr", mem_addr, 32'h40);
        chk("t2_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t2_mem_be", mem_be, 4'b0011);
        chk("t2_stall_c2", d_stall, 1);
        tick();
        chk("t2_stall_c3", d_stall, 1);
        chk("t2_addr_held", mem_addr, 32'h40);
        tick();
        chk("t2_wdata_held", mem_wdata, 32'hDEADBEEF);
        mem_ready = 1; mem_rdata = 32'h55; #1;
        chk("t2_d_ack", d_ack, 1);
        chk("t2_stall_c4", d_stall, 0);
        chk("t2_d_rdata", d_rdata, 32'h55);
        tick();
        chk("t2_mem_req_drop", mem_req, 0);
        d_req = 0; d_we = 0; d_be = 4'hf;
        // 3: contention, 1-cycle memory, streak 4
        if_req = 1; if_addr = 32'h200; d_req = 1; d_addr = 32'h300; mem_ready = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t3_grant%0d_addr", i), mem_addr, (i % 5 == 4) ? 32'h200 : 32'h300);
            chk($sformatf("t3_grant%0d_if_ack", i), if_ack, (i % 5 == 4) ? 1 : 0);
            chk($sformatf("t3_grant%0d_d_ack", i), d_ack, (i % 5 == 4) ? 0 : 1);
            tick();
        end
        // 4: fetch flushed mid-flight drains without ack
        d_req = 0; if_addr = 32'h500; mem_ready = 0;
        tick();
        chk("t4_mem_addr", mem_addr, 32'h500);
        tick();
        if_flush = 1; #1;
        chk("t4_if_ack_flush", if_ack, 0);
        tick();
        if_flush = 0; if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h600; #1;
        chk("t4_drain_req", mem_req, 1);
        tick();
        chk("t4_no_regrant", mem_addr, 32'h500);
        mem_ready = 1; #1;
        chk("t4_drain_if_ack", if_ack, 0);
        chk("t4_drain_d_ack", d_ack, 0);
        tick();
        chk("t4_idle_req", mem_req, 0);
        mem_ready = 0;
        tick();
        chk("t4_next_grant", mem_addr, 32'h600);
        // 5: async reset in 2nd DATA cycle
        tick();
        RESETn = 0; mem_ready = 1; #1;
        chk("t5_rst_mem_req", mem_req, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        chk("t5_rst_d_ack", d_ack, 0);
        mem_ready = 0; #1;
        RESETn = 1;
        tick();
        chk("t5_regrant_req", mem_req, 1);
        chk("t5_regrant_addr", mem_addr, 32'h600);
        mem_ready = 1; #1;
        chk("t5_d_ack", d_ack, 1);
        tick();
        d_req = 0; mem_ready = 0;
        // 6: flush in IDLE blocks the fetch grant
        if_req = 1; if_flush = 1; if_addr = 32'h700;
        tick();
        chk("t6_blocked", mem_req, 0);
        if_flush = 0;
        tick();
        chk("t6_grant_req", mem_req, 1);
        chk("t6_grant_addr", mem_addr, 32'h700);
        mem_ready = 1; #1;
        chk("t6_if_ack", if_ack, 1);
        tick();
        if_req = 0; mem_ready = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the instruction-fetch stage and the data-memory stage of the 5-stage RISC-V pipeline.
- Grants the data stage by default, because it holds the older instruction. A fetch is forced through after a bounded run of data grants, so fetch cannot starve.
- Drives the per-stage stall signals that freeze the pipeline while a stage waits for memory.
- Supports cancelling an in-flight fetch on a taken branch/jump (the PCSrc flush).

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch is pending. Legal range is 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESETn  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_flush  in  1  cancel fetch (branch taken).
- if_addr  in  ADDR_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction; valid when if_ack=1.
- if_ack  out  1  fetch complete (combinational).
- if_stall  out  1  if_req & ~if_ack.
- d_req  in  1  data request; held stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data; valid when d_ack=1.
- d_ack  out  1  data access complete (combinational).
- d_stall  out  1  d_req & ~d_ack.
- mem_req  out  1  memory request (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_be  out  DATA_W/8  memory byte enables (registered).
- mem_ready  in  1  memory completes the access this cycle.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, streak=0.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_be all 0.
  - if_ack=d_ack=0.
  - Reset mid-access abandons the access. The memory must tolerate mem_req dropping without mem_ready.
- States: IDLE, FETCH, DATA, DRAIN.
- IDLE arbitration. The grant is decided in this cycle; the mem_* registers load at the edge and state moves on.
  - Define fetch_ok = if_req & ~if_flush.
  - d_req & fetch_ok & streak==MAX_D_STREAK -> FETCH.
  - else d_req -> DATA.
  - else fetch_ok -> FETCH.
  - else stay in IDLE.
- Grant latching:
  - FETCH grant: mem_addr=if_addr, mem_we=0, mem_be=all 1s, mem_wdata=0.
  - DATA grant: mem_addr=d_addr, mem_we=d_we, mem_be=d_be, mem_wdata=d_wdata.
  - mem_req=1 from the first cycle of FETCH/DATA/DRAIN.
  - mem_* stay stable until the cycle mem_ready=1. On that edge mem_req clears and state goes to IDLE.
- Completion and latency:
  - if_ack = (state==FETCH) & mem_ready & ~if_flush.
  - d_ack = (state==DATA) & mem_ready.
  - rdata outputs pass mem_rdata through.
  - Minimum latency is 2 cycles: grant cycle, then mem_ready in the first FETCH/DATA cycle.
  - A requester may change its request in the cycle after ack. There is no re-grant in the ack cycle because state≠IDLE then.
- Flush:
  - if_flush in FETCH with mem_ready=0 -> DRAIN.
  - In DRAIN, mem_req holds until mem_ready, then the arbiter goes to IDLE with no ack.
  - if_flush with mem_ready=1 in FETCH -> IDLE, no if_ack.
  - if_flush in IDLE blocks the fetch grant that cycle.
  - if_flush has no effect in DATA.
- Streak counter:
  - On a DATA grant with if_req=1: streak+1, saturating at MAX_D_STREAK.
  - On a DATA grant with if_req=0: streak=0.
  - On a FETCH grant: streak=0.
- The stall outputs are purely combinational from req and ack.

Test Plan:
1. Reset, then if_req=1, if_addr=0x100, memory returns mem_ready in the first cycle with rdata=0x00000013 -> mem_req high for exactly 1 cycle, mem_addr=0x100, mem_we=0, if_ack=1 with if_rdata=0x13, if_stall high only in the grant cycle.
2. Store with d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'b0011, memory waits 3 cycles -> mem_* held stable for 3 cycles, d_stall high 3 cycles (grant plus first 2 DATA cycles), d_ack in cycle 4.
3. d_req and if_req both held continuously, MAX_D_STREAK=4, 1-cycle memory -> grants run D,D,D,D,F,D,D,D,D,F; streak resets after each F.
4. Fetch granted, memory latency 4 cycles, if_flush pulsed in the 2nd FETCH cycle -> DRAIN; mem_req stays high until mem_ready; if_ack is never asserted; next grant occurs only after IDLE.
5. RESETn driven low in the 2nd DATA cycle -> mem_req=0 and state=IDLE immediately (asynchronous, no clock edge); no d_ack; after release, the held d_req is re-granted fresh.
6. if_flush=1 in IDLE with only if_req pending -> no grant that cycle; flush drops, then grant on the next cycle.
